// File: rtl/paddle_position_ctrl.sv
// Paddle position register: advances the paddle once per frame from the movement
// requests, with a hold-to-accelerate step size and clamping to the playfield.
module paddle_position_ctrl #(
    parameter int unsigned TOP         = 165,
    parameter int unsigned BOTTOM      = 434,
    parameter int unsigned HEIGHT      = 60,
    parameter int unsigned MIN_STEP    = 2,
    parameter int unsigned MAX_STEP    = 5,
    parameter int unsigned RAMP_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        center_req,
    output logic [10:0] P_upper_limit,
    output logic [10:0] P_down_limit,
    output logic [2:0]  step
);

    localparam int unsigned CNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

    localparam logic [10:0]      TOP_W    = 11'(TOP);
    localparam logic [10:0]      BOTTOM_W = 11'(BOTTOM);
    localparam logic [10:0]      HEIGHT_W = 11'(HEIGHT);
    localparam logic [10:0]      CENTER_W = 11'((TOP + BOTTOM - HEIGHT) / 2);
    localparam logic [2:0]       MIN_W    = 3'(MIN_STEP);
    localparam logic [2:0]       MAX_W    = 3'(MAX_STEP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_t;

    dir_t             state_q, state_d;
    logic [10:0]      upper_q, upper_d;
    logic [10:0]      lower_q, lower_d;
    logic [2:0]       step_q,  step_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    dir_t             move_dir;
    logic [2:0]       cur_step;
    logic [CNT_W-1:0] cur_cnt;
    logic [10:0]      cur_step_w;

    always_comb begin
        state_d    = state_q;
        upper_d    = upper_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        move_dir   = move_up ? UP : DOWN;
        cur_step   = (state_q == move_dir) ? step_q : MIN_W;
        cur_cnt    = (state_q == move_dir) ? cnt_q  : '0;
        cur_step_w = {8'd0, cur_step};

        if (frame_tick) begin
            if (center_req) begin
                upper_d = CENTER_W;
                state_d = IDLE;
                step_d  = MIN_W;
                cnt_d   = '0;
            end else if (move_up ^ move_down) begin
                state_d = move_dir;
                // A direction change restarts from MIN_STEP; clamped moves still ramp
                if (move_up) begin
                    upper_d = ((upper_q - TOP_W) < cur_step_w) ? TOP_W : (upper_q - cur_step_w);
                end else begin
                    upper_d = ((BOTTOM_W - lower_q) < cur_step_w) ? (BOTTOM_W - HEIGHT_W)
                                                                  : (upper_q + cur_step_w);
                end
                if (cur_cnt == CNT_LAST) begin
                    cnt_d  = '0;
                    step_d = (cur_step < MAX_W) ? (cur_step + 3'd1) : MAX_W;
                end else begin
                    cnt_d  = cur_cnt + CNT_W'(1);
                    step_d = cur_step;
                end
            end else begin
                state_d = IDLE;
                step_d  = MIN_W;
                cnt_d   = '0;
            end
        end

        lower_d = upper_d + HEIGHT_W;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            upper_q <= CENTER_W;
            lower_q <= CENTER_W + HEIGHT_W;
            step_q  <= MIN_W;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            upper_q <= upper_d;
            lower_q <= lower_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    assign P_upper_limit = upper_q;
    assign P_down_limit  = lower_q;
    assign step          = step_q;

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Bench for paddle_position_ctrl: directed scenarios plus random frames, all
// compared against a plain-arithmetic model of the paddle.
module tb_paddle_position_ctrl;

    localparam int TOP         = 165;
    localparam int BOTTOM      = 434;
    localparam int HEIGHT      = 60;
    localparam int MIN_STEP    = 2;
    localparam int MAX_STEP    = 5;
    localparam int RAMP_FRAMES = 8;
    localparam int CENTER      = (TOP + BOTTOM - HEIGHT) / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        move_up;
    logic        move_down;
    logic        center_req;
    logic [10:0] up_lim;
    logic [10:0] dn_lim;
    logic [2:0]  step;

    int errors = 0;
    int checks = 0;

    // Model state: direction is -1 (up), 0 (idle), +1 (down)
    int m_pos;
    int m_step;
    int m_cnt;
    int m_dir;

    paddle_position_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .move_up       (move_up),
        .move_down     (move_down),
        .center_req    (center_req),
        .P_upper_limit (up_lim),
        .P_down_limit  (dn_lim),
        .step          (step)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pos  = CENTER;
        m_step = MIN_STEP;
        m_cnt  = 0;
        m_dir  = 0;
    endtask

    task automatic model_frame(input bit up, input bit dn, input bit ctr);
        int d;
        if (ctr) begin
            model_reset();
        end else if (up != dn) begin
            d = up ? -1 : 1;
            if (d != m_dir) begin
                m_dir  = d;
                m_step = MIN_STEP;
                m_cnt  = 0;
            end
            if (d < 0) m_pos = (m_pos - m_step < TOP) ? TOP : m_pos - m_step;
            else       m_pos = (m_pos + m_step > BOTTOM - HEIGHT) ? BOTTOM - HEIGHT : m_pos + m_step;
            m_cnt++;
            if (m_cnt == RAMP_FRAMES) begin
                m_cnt  = 0;
                m_step = (m_step + 1 > MAX_STEP) ? MAX_STEP : m_step + 1;
            end
        end else begin
            m_dir  = 0;
            m_step = MIN_STEP;
            m_cnt  = 0;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_output({tag, "_upper"}, 32'(up_lim), m_pos);
        check_output({tag, "_lower"}, 32'(dn_lim), m_pos + HEIGHT);
        check_output({tag, "_step"},  32'(step),   m_step);
    endtask

    // One clock cycle: drive at negedge, model the edge, sample 1 ns after it
    task automatic apply_stimulus(input bit ft, input bit up, input bit dn, input bit ctr,
                                  input string tag);
        @(negedge clk);
        frame_tick = ft;
        move_up    = up;
        move_down  = dn;
        center_req = ctr;
        @(posedge clk);
        if (ft) model_frame(up, dn, ctr);
        #1;
        check_model(tag);
    endtask

    task automatic frames(input int n, input bit up, input bit dn, input string tag);
        repeat (n) apply_stimulus(1'b1, up, dn, 1'b0, tag);
    endtask

    initial begin
        int mode;
        rst        = 1'b0;
        frame_tick = 1'b0;
        move_up    = 1'b0;
        move_down  = 1'b0;
        center_req = 1'b0;
        model_reset();
        #12;
        check_model("reset");
        check_output("reset_upper_const", 32'(up_lim), 269);
        check_output("reset_lower_const", 32'(dn_lim), 329);
        @(negedge clk);
        rst = 1'b1;

        frames(3, 1'b0, 1'b0, "idle");
        check_output("idle_upper_const", 32'(up_lim), 269);
        check_output("idle_step_const",  32'(step),   2);

        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, "up3");
            check_output("up3_upper_const", 32'(up_lim), 269 - 2 * i);
            check_output("up3_step_const",  32'(step),   2);
        end

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, "recenter");
        for (int i = 1; i <= 16; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, "down16");
            check_output("down16_upper_const", 32'(up_lim),
                         (i <= 8) ? 269 + 2 * i : 285 + 3 * (i - 8));
            check_output("down16_step_const", 32'(step), (i < 8) ? 2 : ((i < 16) ? 3 : 4));
        end

        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, "reverse");
        check_output("reverse_upper_const", 32'(up_lim), 307);
        check_output("reverse_step_const",  32'(step),   2);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, "both");
        check_output("both_upper_const", 32'(up_lim), 307);
        check_output("both_step_const",  32'(step),   2);

        // Asynchronous reset in the middle of a ramp, checked before any clock edge
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, "recenter2");
        frames(16, 1'b0, 1'b1, "ramp4");
        check_output("ramp4_step_const", 32'(step), 4);
        @(negedge clk);
        frame_tick = 1'b0;
        move_down  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        check_output("async_reset_upper_const", 32'(up_lim), 269);
        check_output("async_reset_step_const",  32'(step),   2);
        @(negedge clk);
        rst = 1'b1;

        repeat (6) begin
            frames(7, 1'b1, 1'b0, "walk_up");
            frames(1, 1'b0, 1'b0, "walk_idle");
        end
        frames(1, 1'b1, 1'b0, "walk_up");
        frames(1, 1'b0, 1'b0, "walk_idle");
        frames(8, 1'b1, 1'b0, "walk_up");
        check_output("pre_top_upper_const", 32'(up_lim), 167);
        check_output("pre_top_step_const",  32'(step),   3);
        frames(1, 1'b1, 1'b0, "top_clamp");
        check_output("top_clamp_upper_const", 32'(up_lim), 165);
        check_output("top_clamp_lower_const", 32'(dn_lim), 225);
        frames(1, 1'b1, 1'b0, "top_hold");
        check_output("top_hold_upper_const", 32'(up_lim), 165);

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, "recenter3");
        frames(9, 1'b0, 1'b1, "walk_down");
        frames(1, 1'b0, 1'b0, "walk_idle");
        frames(6, 1'b0, 1'b1, "walk_down");
        frames(1, 1'b0, 1'b0, "walk_idle");
        frames(24, 1'b0, 1'b1, "walk_down");
        check_output("pre_bot_lower_const", 32'(dn_lim), 432);
        check_output("pre_bot_step_const",  32'(step),   5);
        frames(1, 1'b0, 1'b1, "bot_clamp");
        check_output("bot_clamp_lower_const", 32'(dn_lim), 434);
        check_output("bot_clamp_upper_const", 32'(up_lim), 374);

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, "recenter4");
        frames(9, 1'b1, 1'b0, "to200");
        frames(1, 1'b0, 1'b0, "to200_idle");
        repeat (3) begin
            frames(7, 1'b1, 1'b0, "to200");
            frames(1, 1'b0, 1'b0, "to200_idle");
        end
        frames(4, 1'b1, 1'b0, "to200");
        check_output("at200_upper_const", 32'(up_lim), 200);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, "center_up");
        check_output("center_up_upper_const", 32'(up_lim), 269);
        check_output("center_up_step_const",  32'(step),   2);
        frames(1, 1'b1, 1'b0, "nudge");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, "center_no_tick");
        check_output("center_no_tick_const", 32'(up_lim), 267);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "up_no_tick");
        check_output("up_no_tick_const", 32'(up_lim), 267);

        mode = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) mode = int'($urandom_range(0, 3));
            apply_stimulus($urandom_range(0, 2) != 0,
                           (mode == 1) || (mode == 3),
                           (mode == 2) || (mode == 3),
                           $urandom_range(0, 59) == 0,
                           "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
